br_lite_local_ni: RTL and testbench

//  Local network interface between a processing element (PE) and the BrLite router LOCAL port.
//  TX path: buffers PE broadcast/target requests, stamps source=ADDRESS and a rolling id,
//  and injects them into the router with a four-phase req/ack handshake.
//  RX path: accepts flits the router delivers to LOCAL, acks them, drops CLEAR flits and queues the rest for the PE.

---
 rtl/br_lite_local_ni_pkg.sv | 54 +++++
 rtl/br_lite_fifo.sv | 62 ++++++
 rtl/br_lite_local_ni.sv | 175 +++++++++++++++++
 tb/tb_br_lite_local_ni.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_lite_local_ni_pkg.sv
// Shared BrLite types: flit layout, service codes, ports and the local NI FSM states.
package br_lite_local_ni_pkg;

    localparam int NPORT        = 5;
    localparam int BR_ADDR_W    = 16;
    localparam int BR_ID_W      = 5;
    localparam int BR_PAYLOAD_W = 32;

    typedef enum logic [2:0] {
        BR_EAST,
        BR_WEST,
        BR_NORTH,
        BR_SOUTH,
        BR_LOCAL
    } br_port_t;

    typedef enum logic [1:0] {
        BR_SVC_ALL,
        BR_SVC_TGT,
        BR_SVC_CLEAR,
        BR_SVC_BACKTRACK
    } br_svc_t;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]    source;
        logic [BR_ADDR_W-1:0]    target;
        br_svc_t                 service;
        logic [BR_ID_W-1:0]      id;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_data_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_REQ,
        TX_WAIT
    } br_ni_tx_state_t;

    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } br_ni_rx_state_t;

    // PE requests carry only target/service/payload; the NI owns source and id.
    function automatic br_data_t br_stamp(input br_data_t d,
                                          input logic [BR_ADDR_W-1:0] src,
                                          input logic [BR_ID_W-1:0] id);
        br_data_t r;
        r        = d;
        r.source = src;
        r.id     = id;
        return r;
    endfunction

endpackage

// File: rtl/br_lite_fifo.sv
// Show-ahead FIFO with registered full/empty; a push becomes visible at the head one cycle later.
module br_lite_fifo
#(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
)
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;
    logic           full_reg;
    logic           empty_reg;
    logic           do_push;
    logic           do_pop;

    assign do_push    = push_i && !full_reg;
    assign do_pop     = pop_i && !empty_reg;
    assign count_next = count_reg + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Head reads as zero while empty so the PE never sees stale storage.
    assign data_o  = empty_reg ? T'('0) : mem[rd_ptr_reg];
    assign full_o  = full_reg;
    assign empty_o = empty_reg;

endmodule

// File: rtl/br_lite_local_ni.sv
// BrLite local network interface: PE <-> router LOCAL port with four-phase handshakes.
// Optional statistics counters are enabled by defining BR_NI_STATS_EN.
module br_lite_local_ni
    import br_lite_local_ni_pkg::*;
#(
    parameter logic [15:0] ADDRESS  = 16'h0000,
    parameter int          TX_DEPTH = 4,
    parameter int          RX_DEPTH = 4
)
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pe_tx_valid_i,
    output logic        pe_tx_ready_o,
    input  br_data_t    pe_tx_data_i,
    output logic        pe_rx_valid_o,
    input  logic        pe_rx_ready_i,
    output br_data_t    pe_rx_data_o,
    input  logic        local_busy_i,
    output br_data_t    rt_flit_o,
    output logic        rt_req_o,
    input  logic        rt_ack_i,
    input  br_data_t    rt_flit_i,
    input  logic        rt_req_i,
    output logic        rt_ack_o
`ifdef BR_NI_STATS_EN
    ,
    output logic [31:0] tx_cnt_o,
    output logic [31:0] rx_cnt_o,
    output logic [31:0] clr_cnt_o
`endif
);

    br_ni_tx_state_t       tx_state_reg;
    br_ni_rx_state_t       rx_state_reg;
    logic [BR_ID_W-1:0]    id_cnt_reg;

    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    br_data_t              tx_push_data;
    br_data_t              tx_head;

    logic                  rx_take;
    logic                  rx_push;
    logic                  clr_drop;
    logic                  rx_full;
    logic                  rx_empty;

    assign tx_push      = pe_tx_valid_i && !tx_full;
    assign tx_push_data = br_stamp(pe_tx_data_i, ADDRESS, id_cnt_reg);
    assign tx_pop       = (tx_state_reg == TX_REQ) && rt_ack_i;

    assign rx_take  = (rx_state_reg == RX_IDLE) && rt_req_i && !rx_full;
    assign rx_push  = rx_take && (rt_flit_i.service != BR_SVC_CLEAR);
    assign clr_drop = rx_take && (rt_flit_i.service == BR_SVC_CLEAR);

    assign pe_tx_ready_o = !tx_full;
    assign pe_rx_valid_o = !rx_empty;

    br_lite_fifo #(.DEPTH(TX_DEPTH), .T(br_data_t)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .data_i  (tx_push_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    br_lite_fifo #(.DEPTH(RX_DEPTH), .T(br_data_t)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .data_i  (rt_flit_i),
        .pop_i   (pe_rx_ready_i),
        .data_o  (pe_rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_cnt_reg <= '0;
        end else if (tx_push) begin
            id_cnt_reg <= id_cnt_reg + BR_ID_W'(1);
        end
    end

    // Injection: the flit is latched on entry to TX_REQ and held until the next request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_reg <= TX_IDLE;
            rt_req_o     <= 1'b0;
            rt_flit_o    <= '0;
        end else begin
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!tx_empty && !local_busy_i && !rt_ack_i) begin
                        tx_state_reg <= TX_REQ;
                        rt_req_o     <= 1'b1;
                        rt_flit_o    <= tx_head;
                    end
                end
                TX_REQ: begin
                    if (rt_ack_i) begin
                        tx_state_reg <= TX_WAIT;
                        rt_req_o     <= 1'b0;
                    end
                end
                TX_WAIT: begin
                    if (!rt_ack_i) begin
                        tx_state_reg <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_reg <= TX_IDLE;
                    rt_req_o     <= 1'b0;
                end
            endcase
        end
    end

    // Delivery: ack is withheld while the RX FIFO is full, stalling the router losslessly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_reg <= RX_IDLE;
            rt_ack_o     <= 1'b0;
        end else begin
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_take) begin
                        rx_state_reg <= RX_ACK;
                        rt_ack_o     <= 1'b1;
                    end
                end
                RX_ACK: begin
                    if (!rt_req_i) begin
                        rx_state_reg <= RX_IDLE;
                        rt_ack_o     <= 1'b0;
                    end
                end
                default: begin
                    rx_state_reg <= RX_IDLE;
                    rt_ack_o     <= 1'b0;
                end
            endcase
        end
    end

`ifdef BR_NI_STATS_EN
    logic [2:0] stat_inc;
    assign stat_inc = {clr_drop, rx_push, tx_pop};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign tx_cnt_o  = g_stat[0].cnt_reg;
    assign rx_cnt_o  = g_stat[1].cnt_reg;
    assign clr_cnt_o = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_br_lite_local_ni.sv
// Self-checking bench for br_lite_local_ni: TX table plus hand-written RX/reset sequences.
module tb_br_lite_local_ni;
    import br_lite_local_ni_pkg::*;

    localparam logic [15:0] ADDR = 16'hA5C3;

    logic     clk_i;
    logic     rst_ni;
    logic     pe_tx_valid_i;
    logic     pe_tx_ready_o;
    br_data_t pe_tx_data_i;
    logic     pe_rx_valid_o;
    logic     pe_rx_ready_i;
    br_data_t pe_rx_data_o;
    logic     local_busy_i;
    br_data_t rt_flit_o;
    logic     rt_req_o;
    logic     rt_ack_i;
    br_data_t rt_flit_i;
    logic     rt_req_i;
    logic     rt_ack_o;
`ifdef BR_NI_STATS_EN
    logic [31:0] tx_cnt_o;
    logic [31:0] rx_cnt_o;
    logic [31:0] clr_cnt_o;
`endif

    br_lite_local_ni #(.ADDRESS(ADDR), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pe_tx_valid_i (pe_tx_valid_i),
        .pe_tx_ready_o (pe_tx_ready_o),
        .pe_tx_data_i  (pe_tx_data_i),
        .pe_rx_valid_o (pe_rx_valid_o),
        .pe_rx_ready_i (pe_rx_ready_i),
        .pe_rx_data_o  (pe_rx_data_o),
        .local_busy_i  (local_busy_i),
        .rt_flit_o     (rt_flit_o),
        .rt_req_o      (rt_req_o),
        .rt_ack_i      (rt_ack_i),
        .rt_flit_i     (rt_flit_i),
        .rt_req_i      (rt_req_i),
        .rt_ack_o      (rt_ack_o)
`ifdef BR_NI_STATS_EN
        ,
        .tx_cnt_o      (tx_cnt_o),
        .rx_cnt_o      (rx_cnt_o),
        .clr_cnt_o     (clr_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int       cmp_cnt = 0;
    int       err_cnt = 0;
    br_data_t tx_q[$];
    br_data_t rx_q[$];
    logic     rtr_en = 1'b0;
    int       ack_delay = 1;

    typedef struct {
        logic [15:0] target;
        br_svc_t     svc;
        logic [31:0] payload;
        logic [4:0]  exp_id;
    } tx_vec_t;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic br_data_t mk(input logic [15:0] src, input logic [15:0] tgt,
                                    input br_svc_t svc, input logic [4:0] id,
                                    input logic [31:0] pl);
        br_data_t f;
        f.source  = src;
        f.target  = tgt;
        f.service = svc;
        f.id      = id;
        f.payload = pl;
        return f;
    endfunction

    // Router side of the injection handshake; compares each acked flit with the scoreboard.
    initial begin
        int wcnt;
        int cur_delay;
        br_data_t e;
        rt_ack_i  = 1'b0;
        wcnt      = 0;
        cur_delay = 1;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                rt_ack_i = 1'b0;
                wcnt     = 0;
            end else if (rt_ack_i) begin
                if (!rt_req_o) rt_ack_i = 1'b0;
            end else if (rtr_en && rt_req_o) begin
                wcnt++;
                if (wcnt >= cur_delay) begin
                    if (tx_q.size() == 0) begin
                        check("rtr_unexpected_req", {127'd0, rt_req_o}, 128'd0);
                    end else begin
                        e = tx_q.pop_front();
                        check("rtr_flit", rt_flit_o, e);
                        $display("tx inject target=%h svc=%0d id=%0d payload=%h", rt_flit_o.target,
                                 rt_flit_o.service, rt_flit_o.id, rt_flit_o.payload);
                    end
                    rt_ack_i  = 1'b1;
                    wcnt      = 0;
                    cur_delay = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 3));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk_i);
        rtr_en        = 1'b0;
        rst_ni        = 1'b0;
        pe_tx_valid_i = 1'b0;
        pe_tx_data_i  = '0;
        pe_rx_ready_i = 1'b0;
        local_busy_i  = 1'b0;
        rt_flit_i     = '0;
        rt_req_i      = 1'b0;
        tx_q.delete();
        rx_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic pe_push(input logic [15:0] tgt, input br_svc_t svc,
                           input logic [31:0] pl, input logic [4:0] exp_id);
        int n;
        pe_tx_data_i  = mk(16'hFFFF, tgt, svc, 5'h1F, pl);
        pe_tx_valid_i = 1'b1;
        n = 0;
        while (!pe_tx_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("pe_push_ready", {127'd0, pe_tx_ready_o}, 128'd1);
        tx_q.push_back(mk(ADDR, tgt, svc, exp_id, pl));
        @(negedge clk_i);
        pe_tx_valid_i = 1'b0;
    endtask

    task automatic wait_tx_drain(input string nm);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || rt_req_o || rt_ack_i) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        check(nm, {96'd0, tx_q.size()}, 128'd0);
    endtask

    task automatic wait_ack(input logic lvl, input string nm);
        int n;
        n = 0;
        while (rt_ack_o !== lvl && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check(nm, {127'd0, rt_ack_o}, {127'd0, lvl});
    endtask

    task automatic rx_send(input br_data_t f);
        rt_flit_i = f;
        rt_req_i  = 1'b1;
        if (f.service != BR_SVC_CLEAR) rx_q.push_back(f);
        wait_ack(1'b1, "rx_ack_rise");
        rt_req_i = 1'b0;
        wait_ack(1'b0, "rx_ack_fall");
        $display("rx deliver svc=%0d id=%0d payload=%h", f.service, f.id, f.payload);
    endtask

    task automatic pe_pop(input string nm);
        int n;
        br_data_t e;
        n = 0;
        while (!pe_rx_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        e = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
        check(nm, pe_rx_data_o, e);
        $display("rx pop id=%0d payload=%h", pe_rx_data_o.id, pe_rx_data_o.payload);
        pe_rx_ready_i = 1'b1;
        @(negedge clk_i);
        pe_rx_ready_i = 1'b0;
    endtask

    initial begin
        tx_vec_t vec[6];
        logic    seen;
        int      n;
        br_data_t f;

        vec[0] = '{16'h0001, BR_SVC_ALL,   32'h0000_0011, 5'd0};
        vec[1] = '{16'h0203, BR_SVC_TGT,   32'hDEAD_BEEF, 5'd1};
        vec[2] = '{16'hFFFF, BR_SVC_ALL,   32'h0000_0000, 5'd2};
        vec[3] = '{16'h0405, BR_SVC_TGT,   32'hFFFF_FFFF, 5'd3};
        vec[4] = '{16'h0000, BR_SVC_CLEAR, 32'h1234_5678, 5'd4};
        vec[5] = '{16'h7777, BR_SVC_ALL,   32'hA5A5_5A5A, 5'd5};

        rst_ni        = 1'b0;
        pe_tx_valid_i = 1'b0;
        pe_tx_data_i  = '0;
        pe_rx_ready_i = 1'b0;
        local_busy_i  = 1'b0;
        rt_flit_i     = '0;
        rt_req_i      = 1'b0;
        repeat (2) @(negedge clk_i);

        // Reset state
        check("rst_tx_ready", {127'd0, pe_tx_ready_o}, 128'd1);
        check("rst_rt_req",   {127'd0, rt_req_o}, 128'd0);
        check("rst_rt_ack",   {127'd0, rt_ack_o}, 128'd0);
        check("rst_rx_valid", {127'd0, pe_rx_valid_o}, 128'd0);
        check("rst_rt_flit",  rt_flit_o, 128'd0);
        check("rst_rx_data",  pe_rx_data_o, 128'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: single injection, router acks 2 cycles after req; req drops right after ack
        do_reset();
        ack_delay = 2;
        rtr_en    = 1'b1;
        pe_push(16'h0102, BR_SVC_ALL, 32'd5, 5'd0);
        n = 0;
        while (!rt_ack_i && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("t1_ack_seen", {127'd0, rt_ack_i}, 128'd1);
        check("t1_req_drop", {127'd0, rt_req_o}, 128'd0);
        wait_tx_drain("t1_drain");

        // 2: local_busy holds injection off; ids 0 then 1 afterwards
        do_reset();
        local_busy_i = 1'b1;
        ack_delay    = 1;
        rtr_en       = 1'b1;
        pe_push(16'h0011, BR_SVC_TGT, 32'h0000_00AA, 5'd0);
        pe_push(16'h0022, BR_SVC_ALL, 32'h0000_00BB, 5'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            seen |= rt_req_o;
        end
        check("t2_busy_no_req", {127'd0, seen}, 128'd0);
        local_busy_i = 1'b0;
        wait_tx_drain("t2_drain");

        // Table-driven injections, back-to-back with random router ack delays
        do_reset();
        ack_delay = 0;
        rtr_en    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pe_push(vec[i].target, vec[i].svc, vec[i].payload, vec[i].exp_id);
        end
        wait_tx_drain("tbl_drain");

        // 5: id wraps after 2^BR_ID_W pushes
        do_reset();
        ack_delay = 0;
        rtr_en    = 1'b1;
        for (int i = 0; i < (1 << BR_ID_W) + 1; i++) begin
            pe_push(16'h0100 + 16'(i), BR_SVC_TGT, $urandom, 5'(i));
        end
        wait_tx_drain("t5_drain");

        // 3: RX fills, fifth delivery stalls until PE pops; order preserved
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rx_send(mk(16'h1000 + 16'(k), ADDR, (k % 2) ? BR_SVC_TGT : BR_SVC_ALL, 5'(k), $urandom));
        end
        f = mk(16'h1004, ADDR, BR_SVC_ALL, 5'd4, 32'h5555_AAAA);
        rt_flit_i = f;
        rt_req_i  = 1'b1;
        rx_q.push_back(f);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            seen |= rt_ack_o;
        end
        check("t3_full_no_ack", {127'd0, seen}, 128'd0);
        check("t3_full_valid", {127'd0, pe_rx_valid_o}, 128'd1);
        pe_pop("t3_pop_first");
        wait_ack(1'b1, "t3_stalled_ack");
        rt_req_i = 1'b0;
        wait_ack(1'b0, "t3_stalled_ack_fall");
        for (int k = 0; k < 4; k++) begin
            pe_pop("t3_pop_order");
        end
        @(negedge clk_i);
        check("t3_rx_empty", {127'd0, pe_rx_valid_o}, 128'd0);

        // 4: CLEAR flit is acked but never reaches the PE
        rx_send(mk(16'h2000, ADDR, BR_SVC_CLEAR, 5'd7, 32'hC1EA_0000));
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            seen |= pe_rx_valid_o;
        end
        check("t4_clear_dropped", {127'd0, seen}, 128'd0);

        // 6: reset during TX_REQ withdraws the request at once and empties the FIFO
        do_reset();
        pe_push(16'h0303, BR_SVC_ALL, 32'h0000_0066, 5'd0);
        n = 0;
        while (!rt_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("t6_req_up", {127'd0, rt_req_o}, 128'd1);
        rst_ni = 1'b0;
        #1;
        check("t6_req_async_drop", {127'd0, rt_req_o}, 128'd0);
        tx_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("t6_tx_ready", {127'd0, pe_tx_ready_o}, 128'd1);
        check("t6_flit_cleared", rt_flit_o, 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            seen |= rt_req_o;
        end
        check("t6_fifo_empty", {127'd0, seen}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
